pokey_shift_reg: RTL and testbench
==================================

Name: pokey_shift_reg

Overview:
- Parametrised parallel-load / serial-shift register with a built-in bit counter and completion flag.
- Generalises the per-bit shift cell into a full WIDTH-bit register.
- Used by the serial port (SEROUT transmit, SERIN receive) and any other path that needs a framed shift of N bits on the slow clock-enable.
- Adds selectable shift direction, a busy/done handshake, and asynchronous reset, none of which the single-bit cell has.

Parameters:
- WIDTH, 8: register width in bits; legal range 2..32.
- MSB_FIRST, 0: 0 shifts toward bit 0 (LSB out first, sin enters at bit WIDTH-1); 1 shifts toward bit WIDTH-1 (MSB out first, sin enters at bit 0).
- CNT_W, 6: bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-high reset.
- enp, input, 1: slow-clock enable; no state other than done changes unless enp=1.
- load, input, 1: parallel load request.
- shift, input, 1: shift request.
- din, input, WIDTH: parallel load data.
- sin, input, 1: serial input bit.
- q, output, WIDTH: register contents.
- sout, output, 1: serial output; combinational from q. It is q[0] when MSB_FIRST=0 and q[WIDTH-1] when MSB_FIRST=1.
- busy, output, 1: a framed transfer of WIDTH shifts is in progress.
- done, output, 1: single-clk pulse marking completion of a framed transfer.
- count, output, CNT_W: number of shifts performed in the current frame.

Behaviour:
- Reset (asynchronous, any time, including mid-frame): q=0, count=0, busy=0, done=0. sout therefore reads 0.
- All updates below occur on posedge clk with reset=0.
- Priority when enp=1: load over shift over hold.
- Load (enp=1, load=1, shift ignored):
  - q<=din, count<=0, busy<=1.
  - A load during busy=1 aborts the current frame and restarts it; no done pulse is produced for the aborted frame.
- Shift (enp=1, load=0, shift=1):
  - MSB_FIRST=0: q<={sin, q[WIDTH-1:1]}.
  - MSB_FIRST=1: q<={q[WIDTH-2:0], sin}.
  - With busy=1:
    - If count==WIDTH-1, then count<=0, busy<=0, and done<=1 on the same edge.
    - Otherwise count<=count+1.
  - With busy=0: the register still shifts (free-running mode, used for receive), but count stays 0, busy stays 0, and no done is produced.
- Hold (enp=0, or enp=1 with load=0 and shift=0): q, count and busy unchanged.
- done:
  - Registered; high for exactly one clk cycle after the completing edge.
  - Cleared on the next clk edge regardless of enp.
- Latency:
  - q and sout reflect a load or shift one clk after the enabling edge.
  - A frame started by load completes on the WIDTH-th qualifying shift edge; done is visible in the following clk cycle.
- Count arithmetic: unsigned CNT_W bits; never exceeds WIDTH-1; no wrap beyond that value.
- Load and the final shift of a frame asserted together: load wins, a new frame starts, and no done is produced.

Test Plan:
- Reset mid-frame:
  - Stimulus: WIDTH=8, MSB_FIRST=0. Load din=8'hA5, shift 3 times, then assert reset asynchronously between clk edges.
  - Required response: q=0, count=0, busy=0 immediately (before the next edge), and done never asserted.
- LSB-first frame:
  - Stimulus: load 8'hA5, then 8 shifts with enp=1 and sin=1.
  - Required response: sout sequence 1,0,1,0,0,1,0,1; final q=8'hFF; busy falls and done=1 for one clk after the 8th shift edge; count returns to 0.
- MSB-first frame:
  - Stimulus: MSB_FIRST=1; load 8'h3C, then 8 shifts with sin=0.
  - Required response: sout sequence 0,0,1,1,1,1,0,0; final q=8'h00; a single done pulse.
- Enable gating:
  - Stimulus: load 8'h81, then hold shift=1 with enp toggling 1-in-4 clks.
  - Required response: exactly one shift per enp=1 cycle; done occurs after the 8th enp-qualified shift, i.e. 32 clks after the frame starts.
- Load priority and abort:
  - Stimulus: load 8'hF0 with load=1 and shift=1 together at count=7 of the previous frame.
  - Required response: q=8'hF0, count=0, busy=1, no done. The new frame then completes after 8 further shifts.
- Free-running receive:
  - Stimulus: with busy=0, apply 8 shifts with sin pattern 1,1,0,0,1,0,1,0 (MSB_FIRST=0).
  - Required response: q=8'h53, busy stays 0, count stays 0, done never asserted.

Source files
------------

// File: rtl/pokey_shift_reg_if.sv
// Handshake/data bundle for the framed parallel-load / serial-shift register.
// The master drives the requests; the slave returns the register state and frame status.
interface pokey_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
);
    logic             enp;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] din;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;

    modport master (
        output enp, load, shift, din, sin,
        input  q, sout, busy, done, count
    );

    modport slave (
        input  enp, load, shift, din, sin,
        output q, sout, busy, done, count
    );
endinterface

// File: rtl/pokey_shift_reg.sv
// WIDTH-bit parallel-load / serial-shift register gated by a slow clock enable.
// A load opens a frame of WIDTH shifts that ends with a single-cycle done pulse.
module pokey_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = 6
) (
    input  logic               clk,
    input  logic               reset,
    pokey_shift_reg_if.slave   bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_q,     q_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] shifted_s;

    // Shifted image of the register; direction is fixed at elaboration.
    always_comb begin
        if (MSB_FIRST) begin
            shifted_s = {q_q[WIDTH-2:0], bus.sin};
        end else begin
            shifted_s = {bus.sin, q_q[WIDTH-1:1]};
        end
    end

    // Next-state: load beats shift beats hold; done only ever lives one cycle.
    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (bus.enp) begin
            if (bus.load) begin
                q_d     = bus.din;
                count_d = {CNT_W{1'b0}};
                busy_d  = 1'b1;
            end else if (bus.shift) begin
                q_d = shifted_s;
                // Outside a frame the register free-runs without counting.
                if (busy_q) begin
                    if (count_q == LAST_CNT) begin
                        count_d = {CNT_W{1'b0}};
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    count_d = count_q;
                end
            end else begin
                q_d = q_q;
            end
        end else begin
            q_d = q_q;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= {WIDTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sout  = MSB_FIRST ? q_q[WIDTH-1] : q_q[0];
endmodule

// File: tb/tb_pokey_shift_reg.sv
// Directed bench for pokey_shift_reg: one LSB-first and one MSB-first instance,
// hand-computed expectations checked with immediate assertions.
module tb_pokey_shift_reg;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pokey_shift_reg_if #(.WIDTH(8), .CNT_W(6)) a ();
    pokey_shift_reg_if #(.WIDTH(8), .CNT_W(6)) b ();

    pokey_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(6)) dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (a.slave)
    );

    pokey_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(6)) dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] sins;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        a.enp = 1'b0; a.load = 1'b0; a.shift = 1'b0; a.din = 8'h00; a.sin = 1'b0;
        b.enp = 1'b0; b.load = 1'b0; b.shift = 1'b0; b.din = 8'h00; b.sin = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", {24'd0, a.q}, 32'h0);
        check("rst_count", {26'd0, a.count}, 32'h0);
        check("rst_busy", {31'd0, a.busy}, 32'h0);
        check("rst_done", {31'd0, a.done}, 32'h0);
        check("rst_sout", {31'd0, a.sout}, 32'h0);
        #3 reset = 1'b0;

        // LSB-first frame: load A5, shift 8 times with sin=1
        a.enp = 1'b1; a.load = 1'b1; a.din = 8'hA5;
        tick();
        check("lsb_load_q", {24'd0, a.q}, 32'hA5);
        check("lsb_load_busy", {31'd0, a.busy}, 32'h1);
        check("lsb_load_count", {26'd0, a.count}, 32'h0);
        a.load = 1'b0; a.shift = 1'b1; a.sin = 1'b1;
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("lsb_sout%0d", i), {31'd0, a.sout}, {31'd0, pat[i]});
            tick();
            if (i < 7) begin
                check($sformatf("lsb_count%0d", i), {26'd0, a.count}, i + 1);
                check($sformatf("lsb_busy%0d", i), {31'd0, a.busy}, 32'h1);
                check($sformatf("lsb_done%0d", i), {31'd0, a.done}, 32'h0);
            end else begin
                check("lsb_final_q", {24'd0, a.q}, 32'hFF);
                check("lsb_final_busy", {31'd0, a.busy}, 32'h0);
                check("lsb_final_count", {26'd0, a.count}, 32'h0);
                check("lsb_final_done", {31'd0, a.done}, 32'h1);
            end
        end
        a.enp = 1'b0; a.shift = 1'b0;
        tick();
        check("lsb_done_clear_no_enp", {31'd0, a.done}, 32'h0);
        check("lsb_hold_q", {24'd0, a.q}, 32'hFF);

        // Reset mid-frame, asserted between clock edges
        a.enp = 1'b1; a.load = 1'b1; a.din = 8'hA5;
        tick();
        a.load = 1'b0; a.shift = 1'b1; a.sin = 1'b0;
        repeat (3) tick();
        check("mid_count_pre", {26'd0, a.count}, 32'h3);
        a.enp = 1'b0; a.shift = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_q", {24'd0, a.q}, 32'h0);
        check("mid_rst_count", {26'd0, a.count}, 32'h0);
        check("mid_rst_busy", {31'd0, a.busy}, 32'h0);
        check("mid_rst_done", {31'd0, a.done}, 32'h0);
        tick();
        check("mid_rst_done_later", {31'd0, a.done}, 32'h0);
        #3 reset = 1'b0;
        tick();
        check("mid_post_done", {31'd0, a.done}, 32'h0);

        // MSB-first frame on the second instance: load 3C, shift 8 with sin=0
        b.enp = 1'b1; b.load = 1'b1; b.din = 8'h3C;
        tick();
        b.load = 1'b0; b.shift = 1'b1; b.sin = 1'b0;
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("msb_sout%0d", i), {31'd0, b.sout}, {31'd0, pat[7-i]});
            tick();
            check($sformatf("msb_done%0d", i), {31'd0, b.done}, (i == 7) ? 32'h1 : 32'h0);
        end
        check("msb_final_q", {24'd0, b.q}, 32'h00);
        check("msb_final_busy", {31'd0, b.busy}, 32'h0);
        b.enp = 1'b0; b.shift = 1'b0;
        tick();
        check("msb_done_single", {31'd0, b.done}, 32'h0);

        // Enable gating: load 81, shift held high, enp 1-in-4
        a.enp = 1'b1; a.load = 1'b1; a.din = 8'h81;
        tick();
        a.load = 1'b0; a.shift = 1'b1; a.sin = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            a.enp = (k % 4 == 0);
            tick();
            if (k < 32) begin
                check($sformatf("gate_count%0d", k), {26'd0, a.count}, k / 4);
                check($sformatf("gate_done%0d", k), {31'd0, a.done}, 32'h0);
            end else begin
                check("gate_done32", {31'd0, a.done}, 32'h1);
                check("gate_busy32", {31'd0, a.busy}, 32'h0);
                check("gate_q32", {24'd0, a.q}, 32'h00);
            end
        end
        check("gate_q_mid_hold", {24'd0, a.q}, 32'h00);

        // Load priority over the final shift of a frame
        a.enp = 1'b1; a.load = 1'b1; a.shift = 1'b0; a.din = 8'h55;
        tick();
        a.load = 1'b0; a.shift = 1'b1; a.sin = 1'b0;
        repeat (7) tick();
        check("abort_count7", {26'd0, a.count}, 32'h7);
        a.load = 1'b1; a.din = 8'hF0;
        tick();
        check("abort_q", {24'd0, a.q}, 32'hF0);
        check("abort_count", {26'd0, a.count}, 32'h0);
        check("abort_busy", {31'd0, a.busy}, 32'h1);
        check("abort_done", {31'd0, a.done}, 32'h0);
        a.load = 1'b0; a.sin = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("abort_frame_done%0d", i), {31'd0, a.done}, (i == 7) ? 32'h1 : 32'h0);
        end
        check("abort_frame_q", {24'd0, a.q}, 32'hFF);

        // Free-running receive with busy=0
        sins = 8'b0101_0011;
        for (int i = 0; i < 8; i++) begin
            a.sin = sins[i];
            tick();
            check($sformatf("rx_busy%0d", i), {31'd0, a.busy}, 32'h0);
            check($sformatf("rx_count%0d", i), {26'd0, a.count}, 32'h0);
            check($sformatf("rx_done%0d", i), {31'd0, a.done}, 32'h0);
        end
        check("rx_q", {24'd0, a.q}, 32'h53);
        a.enp = 1'b0; a.shift = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
